// File: rtl/input_stage_if.sv
// Bundle of the FT60x receive-side pins and the downstream FWFT stream for input_stage.
interface input_stage_if;
  logic        rxf_n;
  logic [31:0] data_in;
  logic [3:0]  be_in;
  logic        oe_n;
  logic        rd_n;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] counter;
  logic [3:0]  fifo_level;

  // The capture block itself.
  modport slave (
    input  rxf_n, data_in, be_in, out_ready,
    output oe_n, rd_n, out_data, out_be, out_valid, counter, fifo_level
  );

  // The environment: FT60x chip plus the downstream consumer.
  modport master (
    output rxf_n, data_in, be_in, out_ready,
    input  oe_n, rd_n, out_data, out_be, out_valid, counter, fifo_level
  );
endinterface

// File: rtl/input_stage.sv
// FT60x read-side capture: sequences oe_n/rd_n, buffers {be,data} in an
// 8-deep first-word-fall-through FIFO and counts captured words.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus released (oe_n=1, rd_n=1); wait for data and >=4 free slots
// TURN  | one-cycle bus turnaround (oe_n=0, rd_n=1)
// READ  | streaming (oe_n=0, rd_n=0); a word lands on every rxf_n==0 edge
module input_stage (
  input  logic         CLK,
  input  logic         rst_n,
  input_stage_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_READ = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_oe_n;
  logic        r_rd_n;
  logic [35:0] r_mem [0:7];
  logic [2:0]  r_wr_ptr;
  logic [2:0]  r_rd_ptr;
  logic [3:0]  r_level;
  logic [3:0]  w_level_nxt;
  logic [20:0] r_counter;
  logic        w_wr;
  logic        w_pop;
  logic        w_room_turn;
  logic        w_room_low;
  logic        w_valid;
  logic [35:0] w_head;

  // rd_n is registered, so it is low exactly while in READ.
  assign w_wr        = ~r_rd_n & ~bus.rxf_n;
  assign w_valid     = (r_level != 4'd0);
  assign w_pop       = w_valid & bus.out_ready;
  // Starting a burst needs 4 free slots; a burst ends once fewer than 2 remain.
  // Leaving READ at level 7 means the FIFO can never reach a write-while-full.
  assign w_room_turn = (r_level <= 4'd4);
  assign w_room_low  = (w_level_nxt >= 4'd7);

  // Occupancy after this edge's write and pop.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr, w_pop})
      2'b10:   w_level_nxt = r_level + 4'd1;
      2'b01:   w_level_nxt = r_level - 4'd1;
      default: w_level_nxt = r_level;
    endcase
  end

  // Next-state decode for the bus sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!bus.rxf_n && w_room_turn) w_state_nxt = S_TURN;
      S_TURN:  w_state_nxt = S_READ;
      S_READ:  if (bus.rxf_n || w_room_low) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; strobes are registered from the next state so they track it glitch-free.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_oe_n  <= 1'b1;
      r_rd_n  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_oe_n  <= (w_state_nxt == S_IDLE);
      r_rd_n  <= (w_state_nxt != S_READ);
    end
  end

  // FIFO pointers, occupancy and captured-word counter.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_wr_ptr  <= 3'd0;
      r_rd_ptr  <= 3'd0;
      r_level   <= 4'd0;
      r_counter <= 21'd0;
    end else begin
      if (w_wr) begin
        r_wr_ptr  <= r_wr_ptr + 3'd1;
        r_counter <= r_counter + 21'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 3'd1;
      end
      r_level <= w_level_nxt;
    end
  end

  // FIFO storage; not reset, the head is masked while empty instead.
  always_ff @(posedge CLK) begin
    if (rst_n && w_wr) begin
      r_mem[r_wr_ptr] <= {bus.be_in, bus.data_in};
    end
  end

  // A capture must never land on a full FIFO.
  always_ff @(posedge CLK) begin
    if (rst_n && w_wr) begin
      assert (r_level != 4'd8);
    end
  end

  assign w_head         = r_mem[r_rd_ptr];
  assign bus.out_data   = w_valid ? w_head[31:0]  : 32'd0;
  assign bus.out_be     = w_valid ? w_head[35:32] : 4'd0;
  assign bus.out_valid  = w_valid;
  assign bus.oe_n       = r_oe_n;
  assign bus.rd_n       = r_rd_n;
  assign bus.counter    = r_counter;
  assign bus.fifo_level = r_level;

endmodule

// File: tb/tb_input_stage.sv
// Self-checking bench for input_stage: a behavioural FT60x host plus a table of bursts.
module tb_input_stage;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;

  input_stage_if bus ();

  input_stage dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          n;
    logic [31:0] base;
    logic [31:0] step;
    logic [3:0]  be;
    bit          tog;
    int          stall;
    int          exp_cnt;
    int          exp_max;
    int          exp_stall_lvl;
  } vec_t;

  vec_t        vecs [4];
  logic [35:0] host_q [$];
  logic [35:0] rx_q [$];
  int          host_idx;
  int          max_level;
  bit          tog_en;
  bit          tog_phase;
  int          n_tests;
  int          n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Host drives the next unread word; rxf_n optionally toggles every cycle.
  task automatic drive_host();
    if (host_idx < host_q.size()) begin
      bus.data_in = host_q[host_idx][31:0];
      bus.be_in   = host_q[host_idx][35:32];
      bus.rxf_n   = tog_en && tog_phase;
    end else begin
      bus.data_in = 32'd0;
      bus.be_in   = 4'd0;
      bus.rxf_n   = 1'b1;
    end
  endtask

  // One clock: note handshakes before the edge, advance the host, re-drive at negedge.
  task automatic cycle();
    logic cap;
    logic pop;
    cap = rst_n && !bus.rd_n && !bus.rxf_n;
    pop = rst_n && bus.out_valid && bus.out_ready;
    if (pop) rx_q.push_back({bus.out_be, bus.out_data});
    @(posedge CLK);
    if (cap) host_idx++;
    @(negedge CLK);
    if (int'(bus.fifo_level) > max_level) max_level = int'(bus.fifo_level);
    tog_phase = ~tog_phase;
    drive_host();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    host_q.delete();
    host_idx = 0;
    tog_en = 1'b0;
    bus.out_ready = 1'b0;
    drive_host();
    cycle();
    rst_n = 1'b1;
    rx_q.delete();
    max_level = 0;
  endtask

  task automatic run_until_drained(input int n, input int bound, input string name);
    int cyc;
    cyc = 0;
    while ((host_idx < n || int'(rx_q.size()) < n) && cyc < bound) begin
      cycle();
      cyc++;
    end
    check({name, " drain in time"}, 64'(cyc < bound), 64'd1);
  endtask

  initial begin
    vecs[0] = '{5,  32'h11111111, 32'h11111111, 4'hF, 1'b0, 0,  5,  1, 0};
    vecs[1] = '{20, 32'hA0000000, 32'h00000001, 4'hF, 1'b0, 30, 20, 7, 7};
    vecs[2] = '{6,  32'h12345678, 32'h01010101, 4'h0, 1'b1, 0,  6,  1, 0};
    vecs[3] = '{3,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'hA, 1'b0, 0,  3,  1, 0};
    n_tests = 0;
    n_fail = 0;
    host_idx = 0;
    tog_en = 1'b0;
    tog_phase = 1'b0;
    max_level = 0;

    // Reset held two cycles with data pending: bus must stay released.
    rst_n = 1'b0;
    bus.rxf_n = 1'b0;
    bus.data_in = 32'hDEADBEEF;
    bus.be_in = 4'hF;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("rst oe_n", 64'(bus.oe_n), 64'd1);
      check("rst rd_n", 64'(bus.rd_n), 64'd1);
      check("rst out_valid", 64'(bus.out_valid), 64'd0);
      check("rst counter", 64'(bus.counter), 64'd0);
      check("rst fifo_level", 64'(bus.fifo_level), 64'd0);
      check("rst out_data", 64'({bus.out_be, bus.out_data}), 64'd0);
    end

    // oe_n leads rd_n by one cycle; capture shows up one edge later.
    do_reset();
    host_q.push_back({4'h5, 32'hCAFE0001});
    host_q.push_back({4'h3, 32'hCAFE0002});
    bus.out_ready = 1'b1;
    drive_host();
    begin
      int w;
      w = 0;
      while (bus.oe_n !== 1'b0 && w < 10) begin
        cycle();
        w++;
      end
      check("turn oe_n low", 64'(bus.oe_n), 64'd0);
      check("turn rd_n high", 64'(bus.rd_n), 64'd1);
      cycle();
      check("read rd_n low", 64'(bus.rd_n), 64'd0);
      check("read no data yet", 64'(bus.out_valid), 64'd0);
      cycle();
      check("latency out_valid", 64'(bus.out_valid), 64'd1);
      check("latency head", 64'({bus.out_be, bus.out_data}), 64'h5CAFE0001);
      run_until_drained(2, 50, "hand burst");
      check("hand burst counter", 64'(bus.counter), 64'd2);
      check("hand burst word1", 64'(rx_q[1]), 64'h3CAFE0002);
    end

    // Table of bursts.
    for (int r = 0; r < 4; r++) begin
      int cyc;
      int errs;
      vec_t v;
      v = vecs[r];
      do_reset();
      for (int i = 0; i < v.n; i++) host_q.push_back({v.be, v.base + 32'(i) * v.step});
      tog_en = v.tog;
      bus.out_ready = (v.stall == 0);
      drive_host();
      cyc = 0;
      while ((host_idx < v.n || int'(rx_q.size()) < v.n) && cyc < 400) begin
        if (v.stall != 0 && cyc == v.stall) begin
          check($sformatf("row%0d stall level", r), 64'(bus.fifo_level), 64'(v.exp_stall_lvl));
          check($sformatf("row%0d stall rd_n", r), 64'(bus.rd_n), 64'd1);
          check($sformatf("row%0d stall counter", r), 64'(bus.counter), 64'(v.exp_stall_lvl));
        end
        bus.out_ready = (cyc >= v.stall);
        cycle();
        cyc++;
      end
      check($sformatf("row%0d drain in time", r), 64'(cyc < 400), 64'd1);
      repeat (3) cycle();
      check($sformatf("row%0d counter", r), 64'(bus.counter), 64'(v.exp_cnt));
      check($sformatf("row%0d words out", r), 64'(rx_q.size()), 64'(v.n));
      errs = 0;
      for (int i = 0; i < v.n && i < int'(rx_q.size()); i++) begin
        if (rx_q[i] !== {v.be, v.base + 32'(i) * v.step}) errs++;
      end
      check($sformatf("row%0d order errors", r), 64'(errs), 64'd0);
      check($sformatf("row%0d max level", r), 64'(max_level), 64'(v.exp_max));
      check($sformatf("row%0d idle oe_n/rd_n", r), 64'({bus.oe_n, bus.rd_n}), 64'h3);
      check($sformatf("row%0d empty", r), 64'({bus.out_valid, bus.fifo_level}), 64'd0);
    end

    // Reset while streaming with 3 words buffered.
    do_reset();
    for (int i = 0; i < 10; i++) host_q.push_back({4'hF, 32'h0BAD0000 + 32'(i)});
    bus.out_ready = 1'b0;
    drive_host();
    begin
      int w;
      w = 0;
      while (host_idx < 3 && w < 30) begin
        cycle();
        w++;
      end
      check("midread 3 buffered", 64'(bus.fifo_level), 64'd3);
      check("midread in READ", 64'(bus.rd_n), 64'd0);
      rst_n = 1'b0;
      cycle();
      check("midread rst oe_n/rd_n", 64'({bus.oe_n, bus.rd_n}), 64'h3);
      check("midread rst level", 64'(bus.fifo_level), 64'd0);
      check("midread rst counter", 64'(bus.counter), 64'd0);
      check("midread rst head", 64'({bus.out_valid, bus.out_be, bus.out_data}), 64'd0);
      rst_n = 1'b1;
      host_q.delete();
      host_idx = 0;
      rx_q.delete();
      host_q.push_back({4'h1, 32'h600D0001});
      host_q.push_back({4'h2, 32'h600D0002});
      bus.out_ready = 1'b1;
      drive_host();
      cycle();
      check("post rst TURN", 64'({bus.oe_n, bus.rd_n}), 64'h1);
      run_until_drained(2, 50, "post rst");
      check("post rst counter", 64'(bus.counter), 64'd2);
      check("post rst word0", 64'(rx_q[0]), 64'h1600D0001);
    end

    // Counter wrap: deposit a value near the top, then stream 5 words.
    do_reset();
    force dut.r_counter = 21'h1FFFFE;
    #1;
    release dut.r_counter;
    cycle();
    check("wrap preload", 64'(bus.counter), 64'h1FFFFE);
    for (int i = 0; i < 5; i++) host_q.push_back({4'hC, 32'h77770000 + 32'(i)});
    bus.out_ready = 1'b1;
    drive_host();
    run_until_drained(5, 60, "wrap");
    check("wrap counter", 64'(bus.counter), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
